// File: rtl/operand_fetch.sv
// operand_fetch: register-file read stage between decode and the ALU.
// Holds 32 XLEN-bit registers (x0 hard-wired to zero) and captures the two
// source operands plus the destination index of each accepted instruction
// into an output register that drives a valid/ready handshake toward the ALU.
// A writeback in the same cycle as capture is bypassed into the operand. While
// the output is stalled, a writeback to a held source register also refreshes
// the held operand.
//
// Ports:
//   CLK, RSTN           clock, asynchronous active-low reset
//   IN_VALID/IN_READY   upstream handshake (IN_READY is combinational)
//   IN_RS1/RS2/RD_ADDR  decoded register indices
//   WB_EN/ADDR/DATA     register writeback port
//   FLUSH               drop held and incoming instruction
//   OUT_VALID/OUT_READY downstream handshake
//   RS1_VAL, RS2_VAL    registered operand values
//   OUT_RD_ADDR         registered destination index
module operand_fetch #(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [4:0]      IN_RS1_ADDR,
    input  logic [4:0]      IN_RS2_ADDR,
    input  logic [4:0]      IN_RD_ADDR,
    input  logic            WB_EN,
    input  logic [4:0]      WB_ADDR,
    input  logic [XLEN-1:0] WB_DATA,
    input  logic            FLUSH,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] RS1_VAL,
    output logic [XLEN-1:0] RS2_VAL,
    output logic [4:0]      OUT_RD_ADDR
);

    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;

    logic [XLEN-1:0] rf_q [NREGS];

    logic            valid_q, valid_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [AW-1:0]   rs1a_q, rs1a_d;
    logic [AW-1:0]   rs2a_q, rs2a_d;

    logic            accept;
    logic            wb_live;

    // Operand read with x0 forced to zero and same-cycle writeback bypass.
    function automatic logic [XLEN-1:0] read_op(input logic [AW-1:0] a);
        if (a == AW'(0))
            return XLEN'(0);
        else if (wb_live && (WB_ADDR == a))
            return WB_DATA;
        else
            return rf_q[a];
    endfunction

    assign wb_live  = WB_EN && (WB_ADDR != AW'(0));
    assign IN_READY = !valid_q || OUT_READY;
    assign accept   = IN_VALID && IN_READY && !FLUSH;

    // Next-state for the output register and held source addresses.
    always_comb begin
        valid_d = valid_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        rs1a_d  = rs1a_q;
        rs2a_d  = rs2a_q;

        if (accept) begin
            valid_d = 1'b1;
            rs1_d   = read_op(IN_RS1_ADDR);
            rs2_d   = read_op(IN_RS2_ADDR);
            rd_d    = IN_RD_ADDR;
            rs1a_d  = IN_RS1_ADDR;
            rs2a_d  = IN_RS2_ADDR;
        end else if (valid_q && OUT_READY) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            // Stalled: keep held operands coherent with the register file.
            if (wb_live && (WB_ADDR == rs1a_q))
                rs1_d = WB_DATA;
            if (wb_live && (WB_ADDR == rs2a_q))
                rs2_d = WB_DATA;
        end

        if (FLUSH)
            valid_d = 1'b0;
    end

    // Output/handshake state.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            valid_q <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            rs1a_q  <= '0;
            rs2a_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            rs1a_q  <= rs1a_d;
            rs2a_q  <= rs2a_d;
        end
    end

    // Register file; writes are independent of flush and handshake.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < NREGS; i++)
                rf_q[i] <= '0;
        end else if (wb_live) begin
            rf_q[WB_ADDR] <= WB_DATA;
        end
    end

    assign OUT_VALID   = valid_q;
    assign RS1_VAL     = rs1_q;
    assign RS2_VAL     = rs2_q;
    assign OUT_RD_ADDR = rd_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a reference register file and a
// queue of expected output entries pushed on accept and popped on consume.
module tb_operand_fetch;

    localparam int unsigned XLEN = 32;

    logic            CLK;
    logic            RSTN;
    logic            IN_VALID;
    logic            IN_READY;
    logic [4:0]      IN_RS1_ADDR, IN_RS2_ADDR, IN_RD_ADDR;
    logic            WB_EN;
    logic [4:0]      WB_ADDR;
    logic [XLEN-1:0] WB_DATA;
    logic            FLUSH;
    logic            OUT_VALID;
    logic            OUT_READY;
    logic [XLEN-1:0] RS1_VAL, RS2_VAL;
    logic [4:0]      OUT_RD_ADDR;

    operand_fetch #(.XLEN(XLEN)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_RS1_ADDR(IN_RS1_ADDR), .IN_RS2_ADDR(IN_RS2_ADDR), .IN_RD_ADDR(IN_RD_ADDR),
        .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
        .FLUSH(FLUSH),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .RS1_VAL(RS1_VAL), .RS2_VAL(RS2_VAL), .OUT_RD_ADDR(OUT_RD_ADDR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]      a1;
        logic [4:0]      a2;
        logic [4:0]      rd;
        logic [XLEN-1:0] v1;
        logic [XLEN-1:0] v2;
    } ent_t;

    ent_t            sb[$];
    ent_t            last;
    logic [XLEN-1:0] mrf [32];
    int              n_cmp = 0;
    int              n_err = 0;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        last = '{a1: 5'd0, a2: 5'd0, rd: 5'd0, v1: '0, v2: '0};
        for (int i = 0; i < 32; i++) mrf[i] = '0;
    endtask

    function automatic logic [XLEN-1:0] mread(input logic [4:0] a, input logic wen,
                                              input logic [4:0] wa, input logic [XLEN-1:0] wd);
        if (a == 5'd0) return '0;
        if (wen && wa == a) return wd;
        return mrf[a];
    endfunction

    // Compare DUT outputs against the scoreboard head (or last retired values).
    task automatic check_out(input string tag);
        ent_t e;
        e = (sb.size() != 0) ? sb[0] : last;
        chk({tag, ".valid"}, XLEN'(OUT_VALID), XLEN'(sb.size() != 0));
        chk({tag, ".rs1"}, RS1_VAL, e.v1);
        chk({tag, ".rs2"}, RS2_VAL, e.v2);
        chk({tag, ".rd"}, XLEN'(OUT_RD_ADDR), XLEN'(e.rd));
    endtask

    // One cycle: drive at negedge, update model, clock, check at next negedge.
    task automatic step(input string tag, input logic iv, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] rd, input logic wen,
                        input logic [4:0] wa, input logic [XLEN-1:0] wd,
                        input logic fl, input logic ordy);
        logic mv, exp_rdy, acc;
        ent_t e;
        IN_VALID = iv; IN_RS1_ADDR = a1; IN_RS2_ADDR = a2; IN_RD_ADDR = rd;
        WB_EN = wen; WB_ADDR = wa; WB_DATA = wd; FLUSH = fl; OUT_READY = ordy;
        #1;
        mv      = (sb.size() != 0);
        exp_rdy = !mv || ordy;
        chk({tag, ".in_ready"}, XLEN'(IN_READY), XLEN'(exp_rdy));
        acc = iv && exp_rdy && !fl;
        if (mv && !ordy) begin
            if (wen && wa != 5'd0 && wa == sb[0].a1) sb[0].v1 = wd;
            if (wen && wa != 5'd0 && wa == sb[0].a2) sb[0].v2 = wd;
        end
        if (mv && (ordy || fl)) last = sb.pop_front();
        if (acc) begin
            e.a1 = a1; e.a2 = a2; e.rd = rd;
            e.v1 = mread(a1, wen, wa, wd);
            e.v2 = mread(a2, wen, wa, wd);
            sb.push_back(e);
        end
        if (wen && wa != 5'd0) mrf[wa] = wd;
        @(posedge CLK);
        @(negedge CLK);
        check_out(tag);
    endtask

    initial begin
        RSTN = 1'b0; IN_VALID = 1'b0; IN_RS1_ADDR = '0; IN_RS2_ADDR = '0; IN_RD_ADDR = '0;
        WB_EN = 1'b0; WB_ADDR = '0; WB_DATA = '0; FLUSH = 1'b0; OUT_READY = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        #1;
        check_out("reset");
        chk("reset.in_ready", XLEN'(IN_READY), XLEN'(1));
        RSTN = 1'b1;

        // Writeback, then read it back; rs2=x0 reads zero.
        step("wb_x5",   1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b1);
        step("rd_x5",   1'b1, 5'd5, 5'd0, 5'd1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        // Same-cycle bypass on both sources while consuming the previous result.
        step("byp_x7",  1'b1, 5'd7, 5'd7, 5'd2, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 1'b1);
        // Writes to x0 are dropped, including bypass.
        step("wb_x0",   1'b1, 5'd0, 5'd7, 5'd3, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        step("rd_x0",   1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        // Stall: held operands track writebacks; new input is ignored.
        step("st_acc",  1'b1, 5'd5, 5'd3, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        step("st_wb3",  1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 5'd3, 32'h0000_0055, 1'b0, 1'b0);
        step("st_wb5",  1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 5'd5, 32'h0000_AAAA, 1'b0, 1'b0);
        step("st_wb9",  1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 5'd9, 32'h0000_0999, 1'b0, 1'b0);
        // Consume without new input: valid drops, values retained.
        step("drain",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        step("idle",    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

        // Back-to-back streaming with random writebacks and sources.
        for (int i = 0; i < 8; i++) begin
            step($sformatf("strm%0d", i), 1'b1, 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1,
                 5'($urandom_range(0, 31)), $urandom(), 1'b0, 1'b1);
        end

        // Flush with incoming valid while an instruction is held.
        step("fl_acc",  1'b1, 5'd3, 5'd5, 5'd10, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        step("fl_hold", 1'b1, 5'd3, 5'd5, 5'd10, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        step("flush",   1'b1, 5'd1, 5'd2, 5'd11, 1'b1, 5'd12, 32'h0000_0C0C, 1'b1, 1'b0);
        step("fl_wb",   1'b1, 5'd12, 5'd0, 5'd13, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

        // Reset pulsed between edges during a stall.
        step("rs_acc",  1'b1, 5'd12, 5'd5, 5'd14, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        step("rs_hold", 1'b1, 5'd1, 5'd1, 5'd1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        #1 RSTN = 1'b0;
        #1;
        model_reset();
        check_out("rst_async");
        @(negedge CLK);
        RSTN = 1'b1;
        // First edge after release accepts; register file was cleared.
        step("post_rst", 1'b1, 5'd5, 5'd12, 5'd15, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        step("post_hold", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        step("post_idle", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
